// File: rtl/fu_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin functional-unit arbiter.
package fu_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ = 8;
  localparam int DEF_TIMEOUT = 255;

  // Width of the hold counter: enough to hold TIMEOUT, never narrower than 1.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/fu_rr_arbiter_rr_select.sv
// Rotating-priority selector: lowest requester at or after ptr, else lowest overall.
module rr_select
  import fu_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] lo_masked;
  logic [IDX_W-1:0] lo_any;
  logic             hit_masked;

  // Two-pass lowest-index search; scanning downward leaves the lowest hit in place.
  always_comb begin
    lo_masked  = '0;
    lo_any     = '0;
    hit_masked = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_any = IDX_W'(i);
        if (i >= int'(ptr)) begin
          lo_masked  = IDX_W'(i);
          hit_masked = 1'b1;
        end
      end
    end
  end

  assign any = |req;
  assign idx = hit_masked ? lo_masked : lo_any;

endmodule

// File: rtl/fu_rr_arbiter.sv
// Round-robin arbiter sharing one multi-cycle functional unit among NUM_REQ requesters.
// A grant is held until fu_done, a flush, or the watchdog releases it.
module fu_rr_arbiter
  import fu_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       fu_ready,
  input  logic                       fu_done,
  input  logic                       flush,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid,
  output logic                       timeout
);

  localparam int                 IDX_W    = $clog2(NUM_REQ);
  localparam int                 CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]   CNT_LIM  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam bit                 WD_EN    = (TIMEOUT != 0);

  arb_state_e         state;
  arb_state_e         state_nx;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_nx;
  logic [IDX_W-1:0]   ptr_adv;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic [NUM_REQ-1:0] grant_nx;
  logic [IDX_W-1:0]   idx_nx;
  logic               valid_nx;
  logic               timeout_nx;
  logic [NUM_REQ-1:0] req_others;
  logic [IDX_W-1:0]   sel_idle_idx;
  logic               sel_idle_any;
  logic [IDX_W-1:0]   sel_next_idx;
  logic               sel_next_any;
  logic               wd_hit;

  // Pointer value after the current owner finishes (wraps NUM_REQ-1 -> 0).
  assign ptr_adv    = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_W'(1);
  // The finishing owner must not win the back-to-back slot.
  assign req_others = req & ~grant;
  assign wd_hit     = WD_EN && (cnt == CNT_LIM);

  rr_select #(.NUM_REQ(NUM_REQ)) u_sel_idle (
    .req (req),
    .ptr (ptr),
    .idx (sel_idle_idx),
    .any (sel_idle_any)
  );

  // Back-to-back candidate is chosen with the already-advanced pointer.
  rr_select #(.NUM_REQ(NUM_REQ)) u_sel_next (
    .req (req_others),
    .ptr (ptr_adv),
    .idx (sel_next_idx),
    .any (sel_next_any)
  );

  // Next-state and next-output logic; flush overrides, fu_done beats the watchdog.
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    cnt_nx     = cnt;
    grant_nx   = grant;
    idx_nx     = grant_idx;
    valid_nx   = grant_valid;
    timeout_nx = 1'b0;

    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      grant_nx = '0;
      idx_nx   = '0;
      valid_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_idle_any && fu_ready) begin
            state_nx = BUSY;
            cnt_nx   = '0;
            grant_nx = ONE_HOT0 << sel_idle_idx;
            idx_nx   = sel_idle_idx;
            valid_nx = 1'b1;
          end
        end
        BUSY: begin
          if (fu_done) begin
            ptr_nx = ptr_adv;
            if (fu_ready && sel_next_any) begin
              cnt_nx   = '0;
              grant_nx = ONE_HOT0 << sel_next_idx;
              idx_nx   = sel_next_idx;
              valid_nx = 1'b1;
            end else begin
              state_nx = IDLE;
              cnt_nx   = '0;
              grant_nx = '0;
              idx_nx   = '0;
              valid_nx = 1'b0;
            end
          end else if (wd_hit) begin
            ptr_nx     = ptr_adv;
            state_nx   = IDLE;
            cnt_nx     = '0;
            grant_nx   = '0;
            idx_nx     = '0;
            valid_nx   = 1'b0;
            timeout_nx = 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          grant_nx = '0;
          idx_nx   = '0;
          valid_nx = 1'b0;
        end
      endcase
    end
  end

  // State, pointer, hold counter and registered outputs; reset clears all at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      cnt         <= cnt_nx;
      grant       <= grant_nx;
      grant_idx   <= idx_nx;
      grant_valid <= valid_nx;
      timeout     <= timeout_nx;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_valid_match:  assert property (@(posedge clk) disable iff (!rst_n) grant_valid == (|grant));
  a_ptr_range:    assert property (@(posedge clk) disable iff (!rst_n) ptr <= IDX_LAST);
  a_tmo_release:  assert property (@(posedge clk) disable iff (!rst_n) timeout |-> !grant_valid);

endmodule

// File: tb/tb_fu_rr_arbiter.sv
// Self-checking bench for fu_rr_arbiter: directed vector table, hand sequences, random vs model.
module tb_fu_rr_arbiter;

  localparam int N   = 8;
  localparam int TMO = 4;
  localparam int IW  = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          fu_ready;
  logic          fu_done;
  logic          flush;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fu_rr_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .fu_ready    (fu_ready),
    .fu_done     (fu_done),
    .flush       (flush),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  // Reference model: who owns the unit, where the rotation starts, how long held.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_age;
  bit m_tmo;

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic int bit_pos(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] others;
    m_tmo = 0;
    if (flush) begin
      m_busy = 0;
      m_age  = 0;
    end else if (!m_busy) begin
      if (req != '0 && fu_ready) begin
        m_busy  = 1;
        m_owner = pick(req, m_ptr);
        m_age   = 0;
      end
    end else if (fu_done) begin
      m_ptr  = (m_owner + 1) % N;
      others = req;
      others[m_owner] = 1'b0;
      if (fu_ready && others != '0) begin
        m_owner = pick(others, m_ptr);
        m_age   = 0;
      end else begin
        m_busy = 0;
      end
    end else if (TMO != 0 && m_age + 1 == TMO) begin
      m_ptr  = (m_owner + 1) % N;
      m_busy = 0;
      m_tmo  = 1;
    end else begin
      m_age++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = m_busy ? (N'(1) << m_owner) : '0;
    check({tag, " grant"},   32'(grant),       32'(eg));
    check({tag, " valid"},   32'(grant_valid), 32'(m_busy));
    check({tag, " timeout"}, 32'(timeout),     32'(m_tmo));
    if (m_busy) check({tag, " idx"}, 32'(grant_idx), 32'(m_owner));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " grant"},   32'(grant),       32'h0);
    check({tag, " idx"},     32'(grant_idx),   32'h0);
    check({tag, " valid"},   32'(grant_valid), 32'h0);
    check({tag, " timeout"}, 32'(timeout),     32'h0);
  endtask

  // Advance one clock: model consumes the inputs sampled at this edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    bit           rdy;
    bit           done;
    bit           fl;
    logic [N-1:0] g;
    bit           tmo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [N-1:0] r, input bit rdy, input bit dn,
                              input bit fl, input logic [N-1:0] g, input bit tmo);
    vec_t v;
    v.req = r; v.rdy = rdy; v.done = dn; v.fl = fl; v.g = g; v.tmo = tmo;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; req = '0; fu_ready = 1'b0; fu_done = 1'b0; flush = 1'b0;
    model_reset();

    // Back-pressure: request waits while the unit is not ready.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(8'h02, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'h02, 1, 0, 0, 8'h02, 0));
    tbl.push_back(mk(8'h02, 1, 1, 0, 8'h00, 0));   // done, nobody else -> IDLE, ptr=2
    // Sparse fairness: reach ptr=6 then alternate 6,0,6.
    tbl.push_back(mk(8'h20, 1, 0, 0, 8'h20, 0));
    tbl.push_back(mk(8'h41, 1, 1, 0, 8'h40, 0));   // ptr=6 -> 6
    tbl.push_back(mk(8'h41, 1, 1, 0, 8'h01, 0));   // ptr=7 -> 0
    tbl.push_back(mk(8'h41, 1, 1, 0, 8'h40, 0));   // ptr=1 -> 6
    tbl.push_back(mk(8'h00, 1, 1, 0, 8'h00, 0));   // ptr=7, IDLE
    // Watchdog: grant 3, no done, release 4 cycles later.
    tbl.push_back(mk(8'h08, 1, 0, 0, 8'h08, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(8'h08, 1, 0, 0, 8'h08, 0));
    tbl.push_back(mk(8'h08, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'h11, 1, 0, 0, 8'h10, 0));   // ptr=4 after watchdog
    // Flush together with done: ptr must stay 4.
    tbl.push_back(mk(8'h11, 1, 1, 1, 8'h00, 0));
    tbl.push_back(mk(8'h11, 1, 0, 0, 8'h10, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(8'h11, 1, 0, 0, 8'h10, 0));
    // Done on the watchdog-limit cycle: no timeout, ptr=5.
    tbl.push_back(mk(8'h00, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'h21, 1, 0, 0, 8'h20, 0));
    tbl.push_back(mk(8'h00, 1, 1, 0, 8'h00, 0));   // ptr=6
    // Flush in IDLE blocks a new grant.
    tbl.push_back(mk(8'h01, 1, 0, 1, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 0, 8'h00, 0));

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req; fu_ready = tbl[i].rdy; fu_done = tbl[i].done; flush = tbl[i].fl;
      tick();
      check($sformatf("vec%0d grant", i),   32'(grant),       32'(tbl[i].g));
      check($sformatf("vec%0d valid", i),   32'(grant_valid), 32'(|tbl[i].g));
      check($sformatf("vec%0d timeout", i), 32'(timeout),     32'(tbl[i].tmo));
      if (tbl[i].g != '0)
        check($sformatf("vec%0d idx", i), 32'(grant_idx), 32'(bit_pos(tbl[i].g)));
    end

    // Asynchronous reset in the middle of a held grant.
    req = 8'h04; fu_ready = 1'b1; fu_done = 1'b0; flush = 1'b0;
    tick();
    check("pre-reset grant", 32'(grant), 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h01; fu_ready = 1'b1;
    tick();
    check("post-reset grant", 32'(grant), 32'h01);
    check_model("post-reset");
    req = '0; fu_done = 1'b1;
    tick();
    check_model("post-reset release");

    // Fresh reset so rotation starts from ptr=0.
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'hFF; fu_ready = 1'b1; fu_done = 1'b0;
    tick();
    check("rot0 idx", 32'(grant_idx), 32'h0);
    for (int j = 1; j <= 24; j++) begin
      fu_done = (j % 3 == 0);
      tick();
      check($sformatf("rot%0d valid", j), 32'(grant_valid), 32'h1);
      check($sformatf("rot%0d idx", j),   32'(grant_idx),   32'((j / 3) % N));
    end
    req = '0; fu_done = 1'b1;
    tick();
    check_model("rot end");

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      req      = N'($urandom);
      fu_ready = ($urandom_range(0, 3) != 0);
      fu_done  = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 31) == 0);
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fu_rr_arbiter.md
# fu_rr_arbiter

Round-robin arbiter that shares one multi-cycle functional unit (divider, CSR port, memory port) among up to NUM_REQ requesters. Each cycle it picks the first requester at or after a rotating pointer, using lowest-index-first priority selection on a masked request vector. It holds the grant until the unit signals completion, then advances the pointer. A watchdog releases a grant that never completes. It sits between the issue/execute stages and the shared unit.

## Interface
- NUM_REQ, 8, number of requesters; any value ≥ 2, not required to be a power of two
- TIMEOUT, 255, maximum cycles a grant may be held before forced release; 0 disables the watchdog
- clk  in  1  rising-edge clock; the block has one clock
- rst_n  in  1  reset, asynchronous and active-low
- req  in  NUM_REQ  level request per requester; held until the requester's transaction completes
- fu_ready  in  1  shared unit can accept a new transaction this cycle
- fu_done  in  1  granted transaction completes this cycle; ignored in IDLE
- flush  in  1  synchronous pipeline flush
- grant  out  NUM_REQ  one-hot grant, registered
- grant_idx  out  $clog2(NUM_REQ)  binary index of the granted requester
- grant_valid  out  1  a grant is active
- timeout  out  1  one-cycle pulse when the watchdog forces a release

## Operation
- States:
  - IDLE: no grant active.
  - BUSY: grant held.
- Selection (combinational):
  - masked = req & ~((1<<ptr)-1).
  - If masked ≠ 0, pick its lowest set bit; otherwise pick the lowest set bit of req.
  - ptr is the registered round-robin pointer, range 0..NUM_REQ-1.
- IDLE → BUSY: when req ≠ 0 and fu_ready=1. The selected index is registered into grant, grant_idx and grant_valid. The hold counter is cleared.
- BUSY, fu_done=0: grant is held unchanged. Changes on req are ignored, including the granted requester dropping its req. The hold counter increments.
- BUSY, fu_done=1:
  - ptr ← (grant_idx+1) mod NUM_REQ. The wrap from NUM_REQ-1 goes to 0.
  - Same edge: if fu_ready=1 and req with the granted bit masked off is nonzero, the next requester is granted back-to-back, selected using the new ptr. BUSY is kept and the counter is cleared.
  - Otherwise the next state is IDLE.
- Watchdog: when TIMEOUT≠0 and the counter reaches TIMEOUT-1 with fu_done=0:
  - Next cycle the grant is released, the state returns to IDLE and timeout pulses high for one cycle.
  - ptr advances exactly as it would on fu_done.
- flush (highest priority): forces IDLE and clears the grant and counter next edge. ptr is unchanged and timeout is not asserted.
- fu_done together with the watchdog limit: fu_done wins and timeout is not asserted.
- Reset values: state IDLE; grant=0, grant_idx=0, grant_valid=0, timeout=0, ptr=0, counter=0.

## Timing
- Arbitration latency: grant rises the cycle after req is first sampled with fu_ready=1.
- Back-to-back handoff with zero bubble: the old grant drops and the new grant rises on the same edge.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset assertion mid-grant drops every output immediately, asynchronously. Deassertion is synchronized externally.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
- grant is always one-hot or zero, and grant_valid == |grant.

## Structure
- Shared package holds:
  - the arb_state_e enum (IDLE, BUSY);
  - the default NUM_REQ and TIMEOUT constants.
- Sub-module rr_select is combinational. Inputs: req, ptr. Outputs: idx, any. It implements the masked/unmasked two-pass lowest-index search.
- The top level holds the FSM, pointer, watchdog counter and output registers.

## Test plan
- Reset: rst_n=0 mid-BUSY with grant=0x04 → all outputs 0 in the same cycle; after release, req=0x01 → grant=0x01 one cycle later.
- Rotation: req=0xFF held, fu_ready=1, fu_done pulsed every 3rd cycle → grant_idx sequence 0,1,…,7,0 with no bubbles between grants.
- Fairness with sparse requests: ptr=6, req=0x41 → grant_idx=6; after done → 0; after done → 6.
- Back-pressure: req=0x02, fu_ready=0 for 5 cycles → grant_valid stays 0; fu_ready=1 → grant=0x02 next cycle.
- Watchdog: TIMEOUT=4, req=0x08 granted, fu_done never asserted → timeout pulse 4 cycles after the grant; next state IDLE; ptr=4.
- Flush and collisions:
  - flush together with fu_done → IDLE, ptr unchanged, no timeout.
  - fu_done on the watchdog-limit cycle → no timeout pulse.
